spi_slv16: RTL and testbench
============================

# spi_slv16

16-bit SPI responder (slave) that sits on the far end of the team's 16-bit SPI master link and is used as the bus-side front end of peripheral models and on-chip targets. It oversamples SS_n, SCLK and MOSI with the system clock, captures a 16-bit command MSB-first, and returns a preloaded 16-bit response on MISO in the same frame. Bus mode: SCLK idles high, data launched on SCLK fall, sampled on SCLK rise (CPOL=1, CPHA=1); the master holds SCLK high for at least 16 clk after SS_n falls and does not shift on its first SCLK fall.

## Interface
- SYNC_STAGES, 2, synchronizer depth for SS_n/SCLK/MOSI (≥2)
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- SS_n  in  1  slave select from master, active-low, asynchronous to clk
- SCLK  in  1  serial clock from master, asynchronous, ≤ clk/8
- MOSI  in  1  serial data from master
- MISO  out  1  serial data to master; high-Z whenever raw SS_n = 1
- tx_data  in  16  response word for the next frame
- wrt  in  1  one-cycle strobe: load tx_data into tx_buf
- cmd  out  16  last complete command received
- cmd_rdy  out  1  sticky: complete 16-bit frame captured
- clr_rdy  in  1  clears cmd_rdy
- frm_err  out  1  sticky: last frame ended with bit count ≠ 16; cleared by clr_rdy

## Operation
- SS_n, SCLK, MOSI each pass through SYNC_STAGES flops plus one history flop; SCLK rise/fall and SS_n fall/rise are detected on synchronized copies. MOSI uses the same stage count so it stays aligned with the detected SCLK edge.
- tx_buf (16b): loaded from tx_data on wrt, any state; reset 0.
- FSM states IDLE, SHIFT, CHECK.
- IDLE: shift_tx <= tx_buf every cycle (MISO = tx_buf[15] immediately when SS_n falls); bit_cnt <= 0; first_fall <= 1. On synchronized SS_n fall -> SHIFT.
- SHIFT: on SCLK rise: shift_rx <= {shift_rx[14:0], MOSI_sync}, bit_cnt++ (5-bit, saturates at 31). On SCLK fall: if first_fall, clear first_fall without shifting; else shift_tx <= {shift_tx[14:0],1'b0}. On synchronized SS_n rise -> CHECK (edges coincident with SS_n rise are ignored).
- CHECK (1 cycle): bit_cnt == 16 -> cmd <= shift_rx, cmd_rdy <= 1; else frm_err <= 1, cmd unchanged. -> IDLE.
- MISO = SS_n ? 1'bz : shift_tx[15] (raw SS_n, combinational).
- clr_rdy clears cmd_rdy and frm_err; if CHECK sets a flag in the same cycle, set wins.
- wrt during SHIFT affects tx_buf only; response of the current frame is unaffected.
- Reset (async, any state, mid-frame included): state IDLE, cmd 0, cmd_rdy 0, frm_err 0, shift_rx 0, shift_tx 0, tx_buf 0, bit_cnt 0, sync flops 1 for SS_n/SCLK, 0 for MOSI. A frame already in progress when reset releases is ignored until SS_n returns high.

## Timing
- SS_n fall to SHIFT entry: SYNC_STAGES+1 clk.
- MOSI sampled SYNC_STAGES+1 clk after the raw SCLK rise; master must hold MOSI ≥ SYNC_STAGES+2 clk after rise.
- MISO updates SYNC_STAGES+1 clk after raw SCLK fall (≤ 4 clk at default), well inside the master's half-period.
- SS_n rise to cmd_rdy high: SYNC_STAGES+2 clk (4 at default).
- Back-to-back frames: SS_n high ≥ SYNC_STAGES+3 clk between frames.

## Test plan
- Reset: rst_n low mid-frame -> MISO high-Z once SS_n high, cmd=0, cmd_rdy=0, frm_err=0; next full frame received correctly.
- Single frame: wrt tx_data=16'hA5C3, master sends cmd 16'h1234 -> cmd=16'h1234, cmd_rdy=1 exactly 4 clk after SS_n rise, master rd_data=16'hA5C3.
- Back-to-back: frames 16'hFFFF then 16'h0001 with tx 16'h8000 then 16'h7FFF (wrt between) -> cmd sequence FFFF, 0001; master reads 8000, 7FFF.
- wrt mid-frame: tx 16'h1111 loaded, wrt 16'h2222 during bit 5 -> current frame returns 1111, next returns 2222.
- Short frame: SS_n raised after 9 SCLK rises -> frm_err=1, cmd_rdy=0, cmd unchanged; clr_rdy -> frm_err=0.
- clr_rdy coincident with CHECK of a good frame -> cmd_rdy stays 1; clr_rdy alone next cycle -> 0.

Source files
------------

// File: rtl/spi_slv16.sv
// 16-bit SPI responder, CPOL=1/CPHA=1, oversampled by clk.
// Captures a MSB-first command and returns a preloaded response in the same frame.
module spi_slv16 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [15:0] tx_data,
  input  logic        wrt,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_rdy,
  output logic        frm_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   ss_hist_q;
  logic                   sclk_hist_q;
  // Marks which synchronizer positions hold a real sample taken after reset.
  logic [SYNC_STAGES:0]   vld_q;

  state_t      state_q;
  logic [15:0] tx_buf_q;
  logic [15:0] shift_tx_q;
  logic [15:0] shift_rx_q;
  logic [15:0] cmd_q;
  logic [4:0]  bit_cnt_q;
  logic        first_fall_q;
  logic        cmd_rdy_q;
  logic        frm_err_q;

  logic ss_s, sclk_s, mosi_s;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_q   <= '1;
      sclk_sync_q <= '1;
      mosi_sync_q <= '0;
      ss_hist_q   <= 1'b1;
      sclk_hist_q <= 1'b1;
      vld_q       <= '0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      ss_hist_q   <= ss_s;
      sclk_hist_q <= sclk_s;
      vld_q       <= {vld_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // A fall seen against the reset value of the history flop is not a real
  // edge: it means SS_n was already low when reset released.
  assign ss_fall   = ss_hist_q & ~ss_s & vld_q[SYNC_STAGES];
  assign ss_rise   = ~ss_hist_q & ss_s;
  assign sclk_rise = ~sclk_hist_q & sclk_s;
  assign sclk_fall = sclk_hist_q & ~sclk_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tx_buf_q     <= '0;
      shift_tx_q   <= '0;
      shift_rx_q   <= '0;
      cmd_q        <= '0;
      bit_cnt_q    <= '0;
      first_fall_q <= 1'b1;
      cmd_rdy_q    <= 1'b0;
      frm_err_q    <= 1'b0;
    end else begin
      if (wrt) tx_buf_q <= tx_data;
      if (clr_rdy) begin
        cmd_rdy_q <= 1'b0;
        frm_err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          shift_tx_q   <= tx_buf_q;
          bit_cnt_q    <= '0;
          first_fall_q <= 1'b1;
          if (ss_fall) state_q <= SHIFT;
        end
        SHIFT: begin
          if (ss_rise) begin
            state_q <= CHECK;
          end else begin
            if (sclk_rise) begin
              shift_rx_q <= {shift_rx_q[14:0], mosi_s};
              if (bit_cnt_q != 5'd31) bit_cnt_q <= bit_cnt_q + 5'd1;
            end
            // The master launches nothing on its first fall, so bit 15 stays put.
            if (sclk_fall) begin
              if (first_fall_q) first_fall_q <= 1'b0;
              else              shift_tx_q   <= {shift_tx_q[14:0], 1'b0};
            end
          end
        end
        CHECK: begin
          if (bit_cnt_q == 5'd16) begin
            cmd_q     <= shift_rx_q;
            cmd_rdy_q <= 1'b1;
          end else begin
            frm_err_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign frm_err = frm_err_q;
  assign MISO    = SS_n ? 1'bz : shift_tx_q[15];

endmodule

// File: tb/tb_spi_slv16.sv
// Bench for spi_slv16: a bit-banged SPI master plus a frame-level model of
// what the responder should report after each frame.
module tb_spi_slv16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic [15:0] tx_data = 16'h0;
  logic        wrt = 1'b0;
  logic        clr_rdy = 1'b0;
  wire         miso_w;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frm_err;

  pullup (miso_w);

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level model: what the responder must hold between frames.
  logic [15:0] m_tx_buf = 16'h0;
  logic [15:0] m_cmd = 16'h0;
  logic        m_rdy = 1'b0;
  logic        m_err = 1'b0;

  spi_slv16 #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(miso_w), .tx_data(tx_data), .wrt(wrt), .cmd(cmd),
    .cmd_rdy(cmd_rdy), .clr_rdy(clr_rdy), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [15:0] v);
    tx_data = v;
    wrt = 1'b1;
    tick(1);
    wrt = 1'b0;
    m_tx_buf = v;
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
    m_rdy = 1'b0;
    m_err = 1'b0;
  endtask

  // Master: SCLK half-period 6 clk, MOSI launched on fall, MISO sampled at rise.
  task automatic do_frame(input logic [15:0] word, input int nrises, input int wrt_at,
                          input logic [15:0] wrt_val, output logic [15:0] rd);
    rd = 16'h0;
    SS_n = 1'b0;
    MOSI = word[15];
    tick(20);
    for (int i = 0; i < nrises; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? word[15-i] : 1'($urandom);
      if (i == wrt_at) begin
        tx_data = wrt_val;
        wrt = 1'b1;
        tick(1);
        wrt = 1'b0;
        m_tx_buf = wrt_val;
        tick(5);
      end else begin
        tick(6);
      end
      rd = {rd[14:0], miso_w};
      SCLK = 1'b1;
      tick(6);
    end
    SS_n = 1'b1;
  endtask

  task automatic model_frame(input logic [15:0] word, input int nrises);
    if (nrises == 16) begin
      m_cmd = word;
      m_rdy = 1'b1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    check_val($sformatf("%s_cmd", tag), {16'h0, cmd}, {16'h0, m_cmd});
    check_val($sformatf("%s_rdy", tag), {31'h0, cmd_rdy}, {31'h0, m_rdy});
    check_val($sformatf("%s_err", tag), {31'h0, frm_err}, {31'h0, m_err});
  endtask

  task automatic run_frame(input string tag, input logic [15:0] word, input int nrises,
                           input int wrt_at, input logic [15:0] wrt_val);
    logic [15:0] exp_rd;
    logic [15:0] rd;
    exp_rd = m_tx_buf;
    do_frame(word, nrises, wrt_at, wrt_val, rd);
    tick(6);
    model_frame(word, nrises);
    check_state(tag);
    if (nrises == 16)
      check_val($sformatf("%s_miso", tag), {16'h0, rd}, {16'h0, exp_rd});
  endtask

  initial begin
    logic [15:0] rd;
    logic [15:0] word;
    int nr;
    int wa;

    // Reset state
    rst_n = 1'b0;
    tick(3);
    check_state("reset");
    check_val("reset_miso_z", {31'h0, miso_w}, 32'h1);
    rst_n = 1'b1;
    tick(4);

    // Single frame with exact cmd_rdy latency
    load_tx(16'hA5C3);
    tick(2);
    do_frame(16'h1234, 16, -1, 16'h0, rd);
    tick(3);
    check_val("single_rdy_3clk", {31'h0, cmd_rdy}, 32'h0);
    tick(1);
    check_val("single_rdy_4clk", {31'h0, cmd_rdy}, 32'h1);
    model_frame(16'h1234, 16);
    check_state("single");
    check_val("single_miso", {16'h0, rd}, 32'h0000_A5C3);
    tick(2);

    // Reset asserted mid-frame and released while SS_n still low
    load_tx(16'hFFFF);
    SS_n = 1'b0;
    tick(20);
    for (int i = 0; i < 4; i++) begin
      SCLK = 1'b0; MOSI = 1'b1; tick(6);
      SCLK = 1'b1; tick(6);
    end
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    m_tx_buf = 16'h0; m_cmd = 16'h0; m_rdy = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 6; i++) begin
      SCLK = 1'b0; MOSI = 1'b0; tick(6);
      SCLK = 1'b1; tick(6);
    end
    SS_n = 1'b1;
    tick(6);
    check_state("midrst");
    check_val("midrst_miso_z", {31'h0, miso_w}, 32'h1);
    load_tx(16'h0F0F);
    run_frame("after_rst", 16'hBEEF, 16, -1, 16'h0);

    // Back-to-back frames
    load_tx(16'h8000);
    run_frame("b2b0", 16'hFFFF, 16, -1, 16'h0);
    load_tx(16'h7FFF);
    run_frame("b2b1", 16'h0001, 16, -1, 16'h0);

    // wrt during bit 5 only affects the next frame
    load_tx(16'h1111);
    run_frame("wrt_mid0", 16'h5A5A, 16, 5, 16'h2222);
    run_frame("wrt_mid1", 16'hC3C3, 16, -1, 16'h0);

    // Short frame
    pulse_clr();
    run_frame("short9", 16'h9999, 9, -1, 16'h0);
    pulse_clr();
    check_state("short_clr");

    // Long frame: 48 rises must not wrap the bit count back to 16
    run_frame("long48", 16'h4848, 48, -1, 16'h0);
    pulse_clr();
    run_frame("empty", 16'h0000, 0, -1, 16'h0);
    pulse_clr();
    run_frame("long17", 16'h1717, 17, -1, 16'h0);
    pulse_clr();

    // clr_rdy in the same cycle as CHECK of a good frame
    load_tx(16'h3C3C);
    do_frame(16'hCAFE, 16, -1, 16'h0, rd);
    tick(3);
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
    model_frame(16'hCAFE, 16);
    check_val("clr_vs_set_rdy", {31'h0, cmd_rdy}, 32'h1);
    check_val("clr_vs_set_cmd", {16'h0, cmd}, 32'h0000_CAFE);
    pulse_clr();
    check_val("clr_alone_rdy", {31'h0, cmd_rdy}, 32'h0);
    tick(4);

    // Randomized frames
    for (int n = 0; n < 30; n++) begin
      load_tx(16'($urandom));
      word = 16'($urandom);
      nr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 24)) : 16;
      wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      run_frame($sformatf("rnd%0d", n), word, nr, wa, 16'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        pulse_clr();
        check_state($sformatf("rnd%0d_clr", n));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
